// File: rtl/multi_grant_rr_arb_pkg.sv
// -----------------------------------------------------------------------------
// multi_grant_pkg
//   Shared definitions for the multi-grant round-robin arbiter.
//   - Default configuration constants used as parameter defaults by the arbiter.
//   - Index / vector typedefs for the default configuration.
//   - rotate_left / rotate_right: index mapping helpers for rotating WIDTH-entry
//     vectors and data arrays by a fairness pointer (WIDTH is a power of two,
//     so the modulo reduces to a mask).
// -----------------------------------------------------------------------------
package multi_grant_pkg;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_SIZE       = $clog2(DEF_WIDTH);
    localparam int DEF_DATA_WIDTH = 4;
    localparam int DEF_NUM_GNT    = 3;

    typedef logic [DEF_SIZE-1:0]    src_t;
    typedef logic [DEF_WIDTH-1:0]   req_vec_t;
    typedef logic [DEF_NUM_GNT-1:0] slot_vec_t;

    // Source index that lands at rotated position pos: (pos + amt) mod width.
    function automatic int unsigned rotate_left(input int unsigned pos,
                                                input int unsigned amt,
                                                input int unsigned width);
        return (pos + amt) & (width - 1);
    endfunction

    // Rotated position occupied by source index pos: (pos - amt) mod width.
    function automatic int unsigned rotate_right(input int unsigned pos,
                                                 input int unsigned amt,
                                                 input int unsigned width);
        return (pos + width - amt) & (width - 1);
    endfunction

endpackage

// File: rtl/multi_grant_rr_arb_muxn.sv
// -----------------------------------------------------------------------------
// multi_grant_rr_arb_muxn
//   Multi-select priority mux. Scans req_in in priority order (low index first
//   when DIR_L2H != 0, high index first otherwise) and fills up to NUM_SEL
//   compacted output slots with the winners.
// Ports
//   req_in      WIDTH request bits
//   data_in     WIDTH x DATA_WIDTH payloads, entry i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_sum     number of slots filled (min(popcount(req_in), NUM_SEL))
//   data_out    NUM_SEL x DATA_WIDTH selected payloads, unfilled slots are 0
//   enc_req_out NUM_SEL x SIZE encoded winner index per slot, unfilled slots are 0
//   req_out     NUM_SEL x WIDTH one-hot winner per slot, all-zero when unfilled
// -----------------------------------------------------------------------------
module multi_grant_rr_arb_muxn #(
    parameter int WIDTH      = 8,
    parameter int SIZE       = $clog2(WIDTH),
    parameter int DATA_WIDTH = 4,
    parameter int NUM_SEL    = 3,
    parameter int DIR_L2H    = 1,
    parameter int SUM_W      = $clog2(NUM_SEL + 1)
) (
    input  logic [WIDTH-1:0]              req_in,
    input  logic [WIDTH*DATA_WIDTH-1:0]   data_in,
    output logic [SUM_W-1:0]              req_sum,
    output logic [NUM_SEL*DATA_WIDTH-1:0] data_out,
    output logic [NUM_SEL*SIZE-1:0]       enc_req_out,
    output logic [NUM_SEL*WIDTH-1:0]      req_out
);

    // Present the inputs in scan order so the selection loop always walks
    // upward; the direction is folded back in when recording the winner.
    logic [WIDTH-1:0]      scan_req;
    logic [DATA_WIDTH-1:0] scan_data [WIDTH];

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            if (DIR_L2H != 0) begin
                scan_req[i]  = req_in[i];
                scan_data[i] = data_in[i*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                scan_req[i]  = req_in[WIDTH-1-i];
                scan_data[i] = data_in[(WIDTH-1-i)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Slot j takes the first remaining request; the winner is removed before
    // slot j+1 scans, which yields thermometer-compacted slots.
    always_comb begin
        logic [WIDTH-1:0] remaining;
        logic             found;
        remaining   = scan_req;
        found       = 1'b0;
        req_sum     = '0;
        data_out    = '0;
        enc_req_out = '0;
        req_out     = '0;
        for (int j = 0; j < NUM_SEL; j++) begin
            found = 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                if (!found && remaining[i]) begin
                    found        = 1'b1;
                    remaining[i] = 1'b0;
                    data_out[j*DATA_WIDTH +: DATA_WIDTH] = scan_data[i];
                    if (DIR_L2H != 0) begin
                        enc_req_out[j*SIZE +: SIZE] = SIZE'(i);
                        req_out[j*WIDTH + i]        = 1'b1;
                    end else begin
                        enc_req_out[j*SIZE +: SIZE]     = SIZE'(WIDTH - 1 - i);
                        req_out[j*WIDTH + WIDTH - 1 - i] = 1'b1;
                    end
                end
            end
            if (found) begin
                req_sum = req_sum + SUM_W'(1);
            end
        end
    end

endmodule

// File: rtl/multi_grant_rr_arb.sv
// -----------------------------------------------------------------------------
// multi_grant_rr_arb
//   Round-robin scheduler granting up to NUM_GNT of WIDTH valid/ready requesters
//   per cycle and registering the winners into one compacted output bundle.
//   Requests are rotated by a fairness pointer so the muxN priority scan starts
//   at ptr; the encoded winners are un-rotated back to requester indices. After
//   each load the pointer moves just past the last granted requester, which
//   bounds the wait of any continuously valid requester.
// Ports
//   clk        clock, rising edge
//   rst_n      synchronous active-low reset
//   req_valid  WIDTH request valids
//   req_data   WIDTH x DATA_WIDTH payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  WIDTH, requester i's payload is taken this cycle
//   out_valid  NUM_GNT slot valids, thermometer from slot 0
//   out_data   NUM_GNT x DATA_WIDTH slot payloads
//   out_src    NUM_GNT x SIZE requester index per slot
//   out_ready  consumer takes the whole bundle
// -----------------------------------------------------------------------------
module multi_grant_rr_arb
    import multi_grant_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SIZE       = $clog2(WIDTH),
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_GNT    = DEF_NUM_GNT
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              req_valid,
    input  logic [WIDTH*DATA_WIDTH-1:0]   req_data,
    output logic [WIDTH-1:0]              req_ready,
    output logic [NUM_GNT-1:0]            out_valid,
    output logic [NUM_GNT*DATA_WIDTH-1:0] out_data,
    output logic [NUM_GNT*SIZE-1:0]       out_src,
    input  logic                          out_ready
);

    localparam int SUM_W = $clog2(NUM_GNT + 1);

    typedef logic [SIZE-1:0] idx_t;

    logic [SIZE-1:0]               ptr_q, ptr_d;
    logic [NUM_GNT-1:0]            out_valid_q, out_valid_d;
    logic [NUM_GNT*DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [NUM_GNT*SIZE-1:0]       out_src_q, out_src_d;

    logic [DATA_WIDTH-1:0]         req_data_a [WIDTH];
    logic [WIDTH-1:0]              rot_req;
    logic [WIDTH*DATA_WIDTH-1:0]   rot_data;

    logic [SUM_W-1:0]              mux_sum;
    logic [NUM_GNT*DATA_WIDTH-1:0] mux_data;
    logic [NUM_GNT*SIZE-1:0]       mux_enc;
    logic [NUM_GNT*WIDTH-1:0]      mux_req;

    logic [NUM_GNT-1:0]            slot_vld;
    logic [NUM_GNT*SIZE-1:0]       pick_src;
    logic [WIDTH-1:0]              rot_pick;
    logic [WIDTH-1:0]              pick_mask;
    idx_t                          last_src;
    logic                          load;

    always_comb begin
        for (int k = 0; k < WIDTH; k++) begin
            req_data_a[k] = req_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Rotated position k holds requester (k + ptr) mod WIDTH, so position 0
    // is the highest-priority requester.
    always_comb begin
        idx_t s;
        s        = '0;
        rot_req  = '0;
        rot_data = '0;
        for (int k = 0; k < WIDTH; k++) begin
            s          = idx_t'(rotate_left(k, 32'(ptr_q), WIDTH));
            rot_req[k] = req_valid[s];
            rot_data[k*DATA_WIDTH +: DATA_WIDTH] = req_data_a[s];
        end
    end

    multi_grant_rr_arb_muxn #(
        .WIDTH      (WIDTH),
        .SIZE       (SIZE),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_SEL    (NUM_GNT),
        .DIR_L2H    (1),
        .SUM_W      (SUM_W)
    ) u_muxn (
        .req_in      (rot_req),
        .data_in     (rot_data),
        .req_sum     (mux_sum),
        .data_out    (mux_data),
        .enc_req_out (mux_enc),
        .req_out     (mux_req)
    );

    // Per-slot bookkeeping: slot validity, un-rotated source index (natural
    // SIZE-bit wrap), union of rotated winners, and the source of the last
    // filled slot (slot req_sum-1) that drives the pointer update.
    always_comb begin
        slot_vld = '0;
        pick_src = '0;
        rot_pick = '0;
        last_src = '0;
        for (int j = 0; j < NUM_GNT; j++) begin
            slot_vld[j] = |mux_req[j*WIDTH +: WIDTH];
            if (slot_vld[j]) begin
                rot_pick                 = rot_pick | mux_req[j*WIDTH +: WIDTH];
                pick_src[j*SIZE +: SIZE] = mux_enc[j*SIZE +: SIZE] + ptr_q;
                if (SUM_W'(j + 1) == mux_sum) begin
                    last_src = mux_enc[j*SIZE +: SIZE] + ptr_q;
                end
            end
        end
    end

    // Un-rotate the winner set back to requester indices.
    always_comb begin
        idx_t s;
        s         = '0;
        pick_mask = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s            = idx_t'(rotate_right(i, 32'(ptr_q), WIDTH));
            pick_mask[i] = rot_pick[s];
        end
    end

    // rst_n gating keeps req_ready low for the whole reset cycle, even if a
    // bundle was still registered when reset was asserted.
    assign load      = rst_n && (|req_valid) && ((out_valid_q == '0) || out_ready);
    assign req_ready = {WIDTH{load}} & pick_mask;

    always_comb begin
        ptr_d       = ptr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        if (load) begin
            ptr_d       = last_src + idx_t'(1);
            out_valid_d = slot_vld;
            out_data_d  = mux_data;
            out_src_d   = pick_src;
        end else if (out_ready) begin
            // Bundle consumed with nothing to replace it; payload fields hold.
            out_valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            out_valid_q <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
        end else begin
            ptr_q       <= ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_multi_grant_rr_arb.sv
module tb_multi_grant_rr_arb;

    localparam int W      = 8;
    localparam int SZ     = 3;
    localparam int DW     = 4;
    localparam int NG     = 3;
    localparam int STARVE = (W + NG - 1) / NG;

    logic              clk;
    logic              rst_n;
    logic [W-1:0]      req_valid;
    logic [W*DW-1:0]   req_data;
    logic [W-1:0]      req_ready;
    logic [NG-1:0]     out_valid;
    logic [NG*DW-1:0]  out_data;
    logic [NG*SZ-1:0]  out_src;
    logic              out_ready;

    multi_grant_rr_arb #(
        .WIDTH      (W),
        .SIZE       (SZ),
        .DATA_WIDTH (DW),
        .NUM_GNT    (NG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [NG-1:0] vld;
        int            src [NG];
        logic [DW-1:0] data [NG];
    } bundle_t;

    bundle_t      sb_q [$];
    int           checks = 0;
    int           errors = 0;
    int           m_ptr  = 0;
    bit           m_busy = 0;
    int           waits [W];
    logic [W-1:0] last_rr = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: scan requesters in circular order from the pointer,
    // take the first NG valid ones, move the pointer past the last taken.
    task automatic model_eval();
        bundle_t      e;
        logic [W-1:0] mask;
        int           cnt;
        bit           ld;
        e.vld = '0;
        for (int j = 0; j < NG; j++) begin
            e.src[j]  = 0;
            e.data[j] = '0;
        end
        mask = '0;
        cnt  = 0;
        if (!rst_n) begin
            chk("req_ready_in_reset", 32'(req_ready), 32'h0);
            m_ptr   = 0;
            m_busy  = 0;
            last_rr = '0;
            for (int i = 0; i < W; i++) waits[i] = 0;
            return;
        end
        ld = (req_valid != '0) && (!m_busy || out_ready);
        if (ld) begin
            for (int n = 0; n < W; n++) begin
                int s;
                s = (m_ptr + n) % W;
                if (req_valid[s] && cnt < NG) begin
                    mask[s]     = 1'b1;
                    e.vld[cnt]  = 1'b1;
                    e.src[cnt]  = s;
                    e.data[cnt] = req_data[s*DW +: DW];
                    cnt++;
                end
            end
        end
        chk("req_ready", 32'(req_ready), 32'(mask));
        last_rr = mask;
        if (ld) begin
            sb_q.push_back(e);
            m_ptr  = (e.src[cnt-1] + 1) % W;
            m_busy = 1;
            for (int i = 0; i < W; i++) begin
                if (mask[i]) begin
                    waits[i] = 0;
                end else if (req_valid[i]) begin
                    waits[i]++;
                    checks++;
                    if (waits[i] > STARVE - 1) begin
                        errors++;
                        $display("FAIL starvation req=%0d actual_skips=%0d required_max=%0d", i, waits[i], STARVE - 1);
                    end
                end
            end
        end else if (out_ready) begin
            m_busy = 0;
        end
        for (int i = 0; i < W; i++) if (!req_valid[i]) waits[i] = 0;
    endtask

    task automatic step_d(input logic [W-1:0] v, input logic [W*DW-1:0] d,
                          input logic rdy, input logic rst_v);
        @(negedge clk);
        rst_n     = rst_v;
        req_valid = v;
        req_data  = d;
        out_ready = rdy;
        #1;
        model_eval();
    endtask

    task automatic step(input logic [W-1:0] v, input logic rdy, input logic rst_v);
        logic [W*DW-1:0] d;
        for (int i = 0; i < W; i++) d[i*DW +: DW] = DW'($urandom);
        step_d(v, d, rdy, rst_v);
    endtask

    task automatic expect_out(input string tag, input logic [NG-1:0] v,
                              input int s0, input int s1, input int s2);
        int s [NG];
        s = '{s0, s1, s2};
        chk({tag, "_valid"}, 32'(out_valid), 32'(v));
        for (int j = 0; j < NG; j++) begin
            if (v[j]) chk({tag, "_src"}, 32'(out_src[j*SZ +: SZ]), 32'(s[j]));
        end
    endtask

    task automatic compare_bundle(input bundle_t e, input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'(e.vld));
        for (int j = 0; j < NG; j++) begin
            if (e.vld[j]) begin
                chk({tag, "_src"}, 32'(out_src[j*SZ +: SZ]), 32'(e.src[j]));
                chk({tag, "_data"}, 32'(out_data[j*DW +: DW]), 32'(e.data[j]));
            end
        end
    endtask

    // Monitor: a new bundle is expected on any cycle following one where the
    // output was empty or handed over; otherwise the held bundle must not move.
    initial begin
        bit      fresh;
        bundle_t held;
        fresh    = 1'b1;
        held.vld = '0;
        for (int j = 0; j < NG; j++) begin
            held.src[j]  = 0;
            held.data[j] = '0;
        end
        forever begin
            @(negedge clk);
            #2;
            if (out_valid != '0) begin
                chk("thermometer", 32'(out_valid & (out_valid + 3'd1)), 32'h0);
                if (fresh) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_bundle actual_valid=%0h required_valid=0", out_valid);
                    end else begin
                        held = sb_q.pop_front();
                        compare_bundle(held, "bundle");
                    end
                end else begin
                    compare_bundle(held, "held");
                end
            end
            if (rst_n) chk("sb_backlog_le1", 32'(sb_q.size() > 1), 32'h0);
            fresh = (out_valid == '0) || (out_ready == 1'b1) || !rst_n;
        end
    end

    initial begin
        logic [W-1:0]    cv;
        logic [W*DW-1:0] cd;
        for (int i = 0; i < W; i++) waits[i] = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (3) step('0, 1'b0, 1'b0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_out_src", 32'(out_src), 32'h0);

        // All requesters valid: contiguous triples, pointer wraps to 1
        step(8'hFF, 1'b1, 1'b1);
        step(8'hFF, 1'b1, 1'b1);
        expect_out("t1_c1", 3'b111, 0, 1, 2);
        step(8'hFF, 1'b1, 1'b1);
        expect_out("t1_c2", 3'b111, 3, 4, 5);
        step(8'h03, 1'b1, 1'b1);
        expect_out("t1_c3", 3'b111, 6, 7, 0);
        step('0, 1'b1, 1'b1);
        expect_out("t1_ptr1", 3'b011, 1, 0, 0);

        // Sparse request pattern from ptr=0
        step('0, 1'b0, 1'b0);
        step(8'h84, 1'b1, 1'b1);
        chk("t2_req_ready", 32'(req_ready), 32'h84);

        // Stall with new requests pending, then release
        for (int c = 0; c < 4; c++) begin
            step(8'hFF, 1'b0, 1'b1);
            expect_out("t3_stall", 3'b011, 2, 7, 0);
            chk("t3_stall_rr", 32'(req_ready), 32'h0);
        end
        step(8'hFF, 1'b1, 1'b1);
        chk("t3_release_rr", 32'(req_ready), 32'h07);
        step('0, 1'b1, 1'b1);
        expect_out("t3_next", 3'b111, 0, 1, 2);

        // Single requester behind the pointer, then drain
        step(8'h20, 1'b1, 1'b1);
        step(8'h20, 1'b1, 1'b1);
        expect_out("t4_a", 3'b001, 5, 0, 0);
        chk("t4_rr", 32'(req_ready), 32'h20);
        step('0, 1'b1, 1'b1);
        expect_out("t4_b", 3'b001, 5, 0, 0);
        step('0, 1'b1, 1'b1);
        chk("t4_drained", 32'(out_valid), 32'h0);
        step(8'hE0, 1'b1, 1'b1);
        step('0, 1'b1, 1'b1);
        expect_out("t4_ptr6", 3'b111, 6, 7, 5);

        // Reset while a bundle is stalled
        step(8'hFF, 1'b1, 1'b1);
        step(8'hFF, 1'b0, 1'b1);
        step(8'hFF, 1'b0, 1'b0);
        chk("t6_rr_in_reset", 32'(req_ready), 32'h0);
        step(8'hFF, 1'b1, 1'b1);
        chk("t6_out_valid", 32'(out_valid), 32'h0);
        chk("t6_ptr0_rr", 32'(req_ready), 32'h07);
        step('0, 1'b1, 1'b1);

        // Randomized soak: requests held until taken
        cv = '0;
        cd = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < W; i++) begin
                if (!cv[i] || last_rr[i]) begin
                    cv[i]          = ($urandom_range(0, 99) < 45);
                    cd[i*DW +: DW] = DW'($urandom);
                end
            end
            step_d(cv, cd, ($urandom_range(0, 99) < 70), 1'b1);
        end

        repeat (4) step('0, 1'b1, 1'b1);
        chk("sb_drain", 32'(sb_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
